// File: rtl/fir_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_pkg                                                                  |
// | Shared defaults and arithmetic helpers for the unfolded FIR core.        |
// | Contents: default NB/N/J, clog2, accumulator width, requantise/saturate. |
// | Revision: 1.0  initial parametrised release                              |
// +--------------------------------------------------------------------------+
package fir_pkg;

    localparam int NB_DEF = 11;
    localparam int N_DEF  = 8;
    localparam int J_DEF  = 3;

    // ceil(log2(v)) for v >= 1; elaboration-time use only.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Full-precision accumulator: NB x NB products summed over N+1 taps.
    function automatic int acc_w(input int nb, input int n);
        return 2 * nb + clog2(n + 1);
    endfunction

    // Drop the NB-1 fraction bits of a Q2.(2NB-2) sum (optionally rounding
    // half up first) and clamp to the signed NB-bit range.
    function automatic logic signed [63:0] requant_sat(input logic signed [63:0] acc,
                                                       input int nb,
                                                       input bit rnd);
        logic signed [63:0] v;
        logic signed [63:0] lim_hi;
        logic signed [63:0] lim_lo;
        v      = acc + (rnd ? (64'sd1 <<< (nb - 2)) : 64'sd0);
        v      = v >>> (nb - 1);
        lim_hi = (64'sd1 <<< (nb - 1)) - 64'sd1;
        lim_lo = -(64'sd1 <<< (nb - 1));
        if (v > lim_hi)      v = lim_hi;
        else if (v < lim_lo) v = lim_lo;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_unfolded_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_unfolded_lane                                                        |
// | One output lane: N+1 multipliers, 1+PIPE product register stages,        |
// | full-precision sum, requantise/saturate into the lane output register.   |
// | Ports: clk, rst; i_x window (tap i = x[n-i]); i_h coefficients;          |
// |        i_vld valid of the block in the last product stage; o_y result.   |
// | Revision: 1.0  initial parametrised release                              |
// +--------------------------------------------------------------------------+
module fir_unfolded_lane import fir_pkg::*; #(
    parameter int NB    = NB_DEF,
    parameter int N     = N_DEF,
    parameter int PIPE  = 1,
    parameter int ROUND = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [(N+1)*NB-1:0] i_x,
    input  logic [(N+1)*NB-1:0] i_h,
    input  logic                i_vld,
    output logic [NB-1:0]       o_y
);

    localparam int ACC_W = acc_w(NB, N);
    localparam int PW    = 2 * NB;

    logic signed [PW-1:0]    w_prod [N+1];
    logic signed [PW-1:0]    r_prod [PIPE+1][N+1];
    logic signed [ACC_W-1:0] w_acc;
    logic [NB-1:0]           w_q;
    logic [NB-1:0]           r_y;

    always_comb begin
        for (int i = 0; i <= N; i++) begin
            w_prod[i] = PW'($signed(i_x[i*NB +: NB])) * PW'($signed(i_h[i*NB +: NB]));
        end
    end

    // Stage 0 always registers the products; stages 1..PIPE are extra delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= PIPE; s++) begin
                for (int i = 0; i <= N; i++) r_prod[s][i] <= '0;
            end
        end else begin
            r_prod[0] <= w_prod;
            for (int s = 1; s <= PIPE; s++) r_prod[s] <= r_prod[s-1];
        end
    end

    always_comb begin
        w_acc = '0;
        for (int i = 0; i <= N; i++) begin
            w_acc = w_acc + ACC_W'(r_prod[PIPE][i]);
        end
    end

    assign w_q = NB'(requant_sat({{(64-ACC_W){w_acc[ACC_W-1]}}, w_acc}, NB, ROUND != 0));

    // Output holds between valid blocks.
    always_ff @(posedge clk) begin
        if (rst)        r_y <= '0;
        else if (i_vld) r_y <= w_q;
    end

    assign o_y = r_y;

endmodule
`default_nettype wire

// File: rtl/fir_unfolded_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_unfolded_param                                                       |
// | J-parallel direct-form FIR of order N: J samples in, J outputs out per   |
// | valid block, latency 2+PIPE cycles.                                      |
// | Ports: CLK, RST (sync, active high); VIN/DIN input block (lane k =       |
// |        x[mJ+k]); H/H_LD coefficient bus and load strobe; DOUT/VOUT      |
// |        output block; FULL history holds only real samples.              |
// | Revision: 1.0  initial parametrised release                              |
// +--------------------------------------------------------------------------+
module fir_unfolded_param import fir_pkg::*; #(
    parameter int NB    = NB_DEF,
    parameter int N     = N_DEF,
    parameter int J     = J_DEF,
    parameter int PIPE  = 1,
    parameter int ROUND = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                VIN,
    input  logic [J*NB-1:0]     DIN,
    input  logic [(N+1)*NB-1:0] H,
    input  logic                H_LD,
    output logic [J*NB-1:0]     DOUT,
    output logic                VOUT,
    output logic                FULL
);

    // Blocks of history needed; the warm-up count saturates at D+1.
    localparam int D     = (N + J - 1) / J;
    localparam int CNT_W = clog2(D + 2);

    logic [J*NB-1:0]       r_din;
    // Only the newest N samples of the D-block history are ever referenced,
    // so the delay line keeps exactly those (oldest sample in the low bits).
    logic [N*NB-1:0]       r_hist;
    logic [(N+J)*NB-1:0]   w_all;
    logic [(N+1)*NB-1:0]   r_coef;
    // Copy of r_coef taken with each accepted block, so a load coinciding
    // with a capture, or any later load, cannot disturb blocks in flight.
    logic [(N+1)*NB-1:0]   r_coef_blk;
    logic                  r_v1;
    logic [PIPE:0]         r_vp;
    logic                  r_vout;
    logic [CNT_W-1:0]      r_cnt;

    // Chronological sample window: history then current block (lane 0 first).
    assign w_all = {r_din, r_hist};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_din      <= '0;
            r_hist     <= '0;
            r_coef     <= '0;
            r_coef_blk <= '0;
            r_v1       <= 1'b0;
            r_vp       <= '0;
            r_vout     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (VIN) begin
                r_din      <= DIN;
                r_hist     <= w_all[(N+J)*NB-1 -: N*NB];
                r_coef_blk <= r_coef;
                if (r_cnt != CNT_W'(D + 1)) r_cnt <= r_cnt + CNT_W'(1);
            end
            if (H_LD) r_coef <= H;
            r_v1    <= VIN;
            r_vp[0] <= r_v1;
            for (int s = 1; s <= PIPE; s++) r_vp[s] <= r_vp[s-1];
            r_vout  <= r_vp[PIPE];
        end
    end

    generate
        for (genvar k = 0; k < J; k++) begin : g_lane
            logic [(N+1)*NB-1:0] w_win;
            // Output n = current lane k sits at window position N+k.
            for (genvar i = 0; i <= N; i++) begin : g_tap
                assign w_win[i*NB +: NB] = w_all[(N+k-i)*NB +: NB];
            end
            fir_unfolded_lane #(
                .NB    (NB),
                .N     (N),
                .PIPE  (PIPE),
                .ROUND (ROUND)
            ) u_lane (
                .clk   (CLK),
                .rst   (RST),
                .i_x   (w_win),
                .i_h   (r_coef_blk),
                .i_vld (r_vp[PIPE]),
                .o_y   (DOUT[k*NB +: NB])
            );
        end
    endgenerate

    assign VOUT = r_vout;
    assign FULL = (r_cnt == CNT_W'(D + 1));

endmodule
`default_nettype wire

// File: tb/tb_fir_unfolded_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_unfolded_param                                                    |
// | Scoreboard bench: three cores (J=3/N=8 truncating, same with rounding,   |
// | J=4/N=5/PIPE=0) checked against a behavioural FIR model.                 |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_fir_unfolded_param;

    localparam int NB  = 11;
    localparam int NA  = 8;
    localparam int JA  = 3;
    localparam int NBO = 5;
    localparam int JB  = 4;

    logic clk = 1'b0;
    logic rst;
    logic vin_a, hld_a, vin_b, hld_b;
    logic [JA*NB-1:0]      din_a, dout_a, dout_r;
    logic [(NA+1)*NB-1:0]  h_a;
    logic [JB*NB-1:0]      din_b, dout_b;
    logic [(NBO+1)*NB-1:0] h_b;
    logic vout_a, full_a, vout_r, full_r, vout_b, full_b;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int due;
        int y [4];
    } exp_t;

    exp_t q_a[$], q_r[$], q_b[$];
    int prev_a [4], prev_r [4], prev_b [4];
    int xs_a[$], xs_b[$];
    int coef_a [NA+1], hnext_a [NA+1];
    int coef_b [NBO+1], hnext_b [NBO+1];
    int cnt_a, cnt_b;

    fir_unfolded_param #(.NB(NB), .N(NA), .J(JA), .PIPE(1), .ROUND(0)) dut_a (
        .CLK(clk), .RST(rst), .VIN(vin_a), .DIN(din_a), .H(h_a), .H_LD(hld_a),
        .DOUT(dout_a), .VOUT(vout_a), .FULL(full_a));

    fir_unfolded_param #(.NB(NB), .N(NA), .J(JA), .PIPE(1), .ROUND(1)) dut_r (
        .CLK(clk), .RST(rst), .VIN(vin_a), .DIN(din_a), .H(h_a), .H_LD(hld_a),
        .DOUT(dout_r), .VOUT(vout_r), .FULL(full_r));

    fir_unfolded_param #(.NB(NB), .N(NBO), .J(JB), .PIPE(0), .ROUND(0)) dut_b (
        .CLK(clk), .RST(rst), .VIN(vin_b), .DIN(din_b), .H(h_b), .H_LD(hld_b),
        .DOUT(dout_b), .VOUT(vout_b), .FULL(full_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int lane_of(input logic [4*NB-1:0] v, input int k);
        logic [NB-1:0] s;
        s = v[k*NB +: NB];
        return int'($signed(s));
    endfunction

    function automatic int rnd11();
        return int'($urandom_range(2047)) - 1024;
    endfunction

    // Reference requantisation: drop 10 fraction bits, optional half-up, clamp.
    function automatic int requant(input longint acc, input bit rnd);
        longint v;
        v = acc + (rnd ? longint'(512) : longint'(0));
        v = v >>> 10;
        if (v > 1023)  v = 1023;
        if (v < -1024) v = -1024;
        return int'(v);
    endfunction

    function automatic longint acc_a(input int n);
        longint s = 0;
        for (int i = 0; i <= NA; i++)
            if (n - i >= 0) s += longint'(coef_a[i]) * longint'(xs_a[n-i]);
        return s;
    endfunction

    function automatic longint acc_b(input int n);
        longint s = 0;
        for (int i = 0; i <= NBO; i++)
            if (n - i >= 0) s += longint'(coef_b[i]) * longint'(xs_b[n-i]);
        return s;
    endfunction

    // Drive one cycle on cores A/R; block model uses coefficients before any load.
    task automatic blk_a(input bit v, input int x0, input int x1, input int x2, input bit ld);
        exp_t ea, er;
        int xv [3];
        int n;
        longint acc;
        xv = '{x0, x1, x2};
        vin_a = v;
        hld_a = ld;
        for (int k = 0; k < JA; k++) din_a[k*NB +: NB] = NB'(xv[k]);
        for (int i = 0; i <= NA; i++) h_a[i*NB +: NB] = NB'(hnext_a[i]);
        if (v) begin
            for (int k = 0; k < JA; k++) xs_a.push_back(xv[k]);
            ea.due = cyc + 4;
            er.due = cyc + 4;
            ea.y[3] = 0;
            er.y[3] = 0;
            for (int k = 0; k < JA; k++) begin
                n   = xs_a.size() - JA + k;
                acc = acc_a(n);
                ea.y[k] = requant(acc, 1'b0);
                er.y[k] = requant(acc, 1'b1);
            end
            q_a.push_back(ea);
            q_r.push_back(er);
            if (cnt_a < 4) cnt_a++;
        end
        if (ld) coef_a = hnext_a;
        @(posedge clk);
        #2;
    endtask

    task automatic blk_b(input bit v, input int x0, input int x1, input int x2, input int x3,
                         input bit ld);
        exp_t eb;
        int xv [4];
        xv = '{x0, x1, x2, x3};
        vin_b = v;
        hld_b = ld;
        for (int k = 0; k < JB; k++) din_b[k*NB +: NB] = NB'(xv[k]);
        for (int i = 0; i <= NBO; i++) h_b[i*NB +: NB] = NB'(hnext_b[i]);
        if (v) begin
            for (int k = 0; k < JB; k++) xs_b.push_back(xv[k]);
            eb.due = cyc + 3;
            for (int k = 0; k < JB; k++) eb.y[k] = requant(acc_b(xs_b.size() - JB + k), 1'b0);
            q_b.push_back(eb);
            if (cnt_b < 3) cnt_b++;
        end
        if (ld) coef_b = hnext_b;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_a(input int n);
        repeat (n) blk_a(1'b0, rnd11(), rnd11(), rnd11(), 1'b0);
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        vin_a = 1'b0; hld_a = 1'b0; vin_b = 1'b0; hld_b = 1'b0;
        q_a.delete(); q_r.delete(); q_b.delete();
        xs_a.delete(); xs_b.delete();
        foreach (prev_a[k]) begin prev_a[k] = 0; prev_r[k] = 0; prev_b[k] = 0; end
        foreach (coef_a[i]) coef_a[i] = 0;
        foreach (coef_b[i]) coef_b[i] = 0;
        cnt_a = 0;
        cnt_b = 0;
        repeat (ncyc) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        check("rst_vout_a", int'(vout_a), 0);
        check("rst_full_a", int'(full_a), 0);
        check("rst_vout_b", int'(vout_b), 0);
        for (int k = 0; k < JA; k++) check("rst_dout_a", lane_of({11'b0, dout_a}, k), 0);
    endtask

    task automatic impulse_a();
        foreach (hnext_a[i]) hnext_a[i] = 64 * (i + 1);
        blk_a(1'b0, 0, 0, 0, 1'b1);
        blk_a(1'b1, 1023, 0, 0, 1'b0);
        repeat (4) blk_a(1'b1, 0, 0, 0, 1'b0);
        idle_a(6);
    endtask

    always @(posedge clk) begin
        bit hit;
        exp_t e;
        #1;
        if (mon_en) begin
            hit = (q_a.size() > 0) && (q_a[0].due == cyc);
            check("a_vout", int'(vout_a), int'(hit));
            check("a_full", int'(full_a), int'(cnt_a >= 4));
            if (hit) begin
                e = q_a.pop_front();
                for (int k = 0; k < JA; k++) prev_a[k] = e.y[k];
            end
            for (int k = 0; k < JA; k++)
                check(hit ? "a_dout" : "a_hold", lane_of({11'b0, dout_a}, k), prev_a[k]);

            hit = (q_r.size() > 0) && (q_r[0].due == cyc);
            check("r_vout", int'(vout_r), int'(hit));
            check("r_full", int'(full_r), int'(cnt_a >= 4));
            if (hit) begin
                e = q_r.pop_front();
                for (int k = 0; k < JA; k++) prev_r[k] = e.y[k];
            end
            for (int k = 0; k < JA; k++)
                check(hit ? "r_dout" : "r_hold", lane_of({11'b0, dout_r}, k), prev_r[k]);

            hit = (q_b.size() > 0) && (q_b[0].due == cyc);
            check("b_vout", int'(vout_b), int'(hit));
            check("b_full", int'(full_b), int'(cnt_b >= 3));
            if (hit) begin
                e = q_b.pop_front();
                for (int k = 0; k < JB; k++) prev_b[k] = e.y[k];
            end
            for (int k = 0; k < JB; k++)
                check(hit ? "b_dout" : "b_hold", lane_of(dout_b, k), prev_b[k]);
        end
    end

    initial begin
        int pat [6];
        bit v, ld;
        h_a = '0; h_b = '0; din_a = '0; din_b = '0;
        foreach (hnext_a[i]) hnext_a[i] = 0;
        foreach (hnext_b[i]) hnext_b[i] = 0;
        do_reset(2);
        mon_en = 1'b1;

        // Impulse: expect (63,127,191) (255,319,383) (447,511,575) then zeros.
        impulse_a();

        // Same impulse stream with VIN gaps; gap cycles carry junk on DIN.
        do_reset(1);
        foreach (hnext_a[i]) hnext_a[i] = 64 * (i + 1);
        blk_a(1'b0, 0, 0, 0, 1'b1);
        pat = '{1, 0, 0, 1, 0, 1};
        for (int c = 0; c < 6; c++) begin
            if (pat[c] == 0)      blk_a(1'b0, rnd11(), rnd11(), rnd11(), 1'b0);
            else if (c == 0)      blk_a(1'b1, 1023, 0, 0, 1'b0);
            else                  blk_a(1'b1, 0, 0, 0, 1'b0);
        end
        repeat (3) blk_a(1'b1, 0, 0, 0, 1'b0);
        idle_a(6);

        // Reset with two blocks in flight, then the impulse again.
        do_reset(1);
        foreach (hnext_a[i]) hnext_a[i] = 64 * (i + 1);
        blk_a(1'b0, 0, 0, 0, 1'b1);
        blk_a(1'b1, 1023, 0, 0, 1'b0);
        blk_a(1'b1, 0, 0, 0, 1'b0);
        do_reset(1);
        impulse_a();

        // Saturation: all taps and samples at -1024.
        do_reset(1);
        foreach (hnext_a[i]) hnext_a[i] = -1024;
        blk_a(1'b0, 0, 0, 0, 1'b1);
        repeat (6) blk_a(1'b1, -1024, -1024, -1024, 1'b0);
        idle_a(6);

        // Rounding: h0 = 1, x = 512 -> truncating core 0, rounding core 1.
        do_reset(1);
        foreach (hnext_a[i]) hnext_a[i] = (i == 0) ? 1 : 0;
        blk_a(1'b0, 0, 0, 0, 1'b1);
        repeat (3) blk_a(1'b1, 512, 512, 512, 1'b0);
        idle_a(6);

        // Coefficient swap coinciding with acceptance of a block.
        do_reset(1);
        foreach (hnext_a[i]) hnext_a[i] = 64 * (i + 1);
        blk_a(1'b0, 0, 0, 0, 1'b1);
        blk_a(1'b1, 1023, 0, 0, 1'b0);
        foreach (hnext_a[i]) hnext_a[i] = -32 * (i + 2);
        blk_a(1'b1, 500, -300, 7, 1'b1);
        blk_a(1'b1, 300, 1000, -900, 1'b0);
        // Random traffic with gaps and occasional reloads.
        for (int c = 0; c < 40; c++) begin
            v  = ($urandom_range(99) < 70);
            ld = ($urandom_range(99) < 10);
            if (ld) foreach (hnext_a[i]) hnext_a[i] = rnd11();
            blk_a(v, rnd11(), rnd11(), rnd11(), ld);
        end
        idle_a(6);

        // J=4, N=5, PIPE=0 core with random traffic and reloads.
        do_reset(1);
        foreach (hnext_b[i]) hnext_b[i] = rnd11();
        blk_b(1'b0, 0, 0, 0, 0, 1'b1);
        for (int c = 0; c < 60; c++) begin
            v  = ($urandom_range(99) < 70);
            ld = ($urandom_range(99) < 10);
            if (ld) foreach (hnext_b[i]) hnext_b[i] = rnd11();
            blk_b(v, rnd11(), rnd11(), rnd11(), rnd11(), ld);
        end
        repeat (6) blk_b(1'b0, rnd11(), rnd11(), rnd11(), rnd11(), 1'b0);

        check("a_drain", q_a.size(), 0);
        check("r_drain", q_r.size(), 0);
        check("b_drain", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_unfolded_param.md
Name: fir_unfolded_param

Overview:
- Parametrised J-parallel (unfolded) direct-form FIR core of order N: accepts a block of J consecutive samples per valid cycle and produces J outputs per valid cycle.
- Next generation of the fixed 3-way, order-8, 11-bit unfolded filter.
- Adds a generic lane count, order and width.
- Adds a configurable multiplier pipeline, selectable truncation/rounding, output saturation, a coefficient load strobe and a warm-up indicator.
- Sits between the data source and data sink blocks of the filter test environment.

Parameters:
- NB, 11, data and coefficient width; signed two's complement Q1.(NB-1).
- N, 8, filter order; number of taps is N+1.
- J, 3, unfolding factor (lanes per block); J >= 1.
- PIPE, 1, extra register stages after the multipliers; 0..2.
- ROUND, 0, 0 = truncate, 1 = round half up on output requantisation.

Ports:
- CLK  in  1  clock; all registers update on its rising edge.
- RST  in  1  synchronous active-high reset.
- VIN  in  1  input block valid.
- DIN  in  J*NB  input block; lane k = DIN[(k+1)*NB-1 : k*NB] = x[mJ+k].
- H  in  (N+1)*NB  coefficient bus; tap i = H[(i+1)*NB-1 : i*NB].
- H_LD  in  1  load strobe: H is captured into the coefficient register.
- DOUT  out  J*NB  output block; lane k = y[mJ+k].
- VOUT  out  1  output block valid.
- FULL  out  1  delay line holds only real samples; warm-up complete.

Behaviour:
- Reset (RST=1 at a CLK edge) clears the following to 0:
  - input register, delay line, coefficient register, pipeline data and valid bits;
  - DOUT, VOUT, FULL;
  - warm-up counter.
- Reset mid-stream discards all in-flight blocks: no VOUT for them.
- Function: y[n] = sum over i=0..N of h[i]*x[n-i], with n = mJ+k.
- The delay line stores the previous D = ceil(N/J) blocks. It shifts one block only on cycles with VIN=1. With VIN=0 the delay line and warm-up counter hold.
- Pipeline (2+PIPE stages total):
  - Stage 1: registers DIN into the input register on VIN=1.
  - Stage 2: per lane, N+1 products of NB x NB giving 2NB-1 significant bits, followed by PIPE product register stages.
  - Final stage: sum, requantise, saturate into the DOUT register.
- A valid bit travels alongside the data and always advances.
- Latency: VIN=1 sampled at edge t gives VOUT=1 after edge t+2+PIPE, with that block on DOUT.
- DOUT updates only when its valid bit is 1; otherwise DOUT holds its last value and VOUT=0.
- Gaps in VIN produce identical results to a contiguous stream, with the same gap pattern on VOUT.
- Arithmetic:
  - Products sign-extend into an accumulator of 2NB+clog2(N+1) bits; full-precision sum, no intermediate truncation.
  - Output = accumulator bits [2NB-2 : NB-1].
  - ROUND=1 adds 2^(NB-2) before the shift.
  - The result saturates to [-2^(NB-1), 2^(NB-1)-1].
- Coefficients:
  - H_LD=1 at edge t loads H. The new coefficients apply to blocks whose stage-1 capture occurs at edge t+1 or later.
  - A block accepted at edge t together with H_LD uses the old coefficients.
  - Blocks already in flight keep the coefficients they were multiplied with. The multiply stage reads the coefficient register aligned with each block's valid bit: each block carries a coefficient-set tag, or the coefficient register is double-buffered.
- FULL: a saturating counter increments on each accepted block. FULL=1 once the count reaches D+1. Before that, outputs are computed with zeros in the unfilled history; no other special handling.
- Simultaneous RST and VIN/H_LD: reset wins.

Decomposition:
- Shared package fir_pkg contains:
  - default NB, N, J;
  - a clog2 function;
  - accumulator width function ACC_W(NB, N);
  - a requantise/saturate function parametrised by ROUND.
- Sub-module fir_unfolded_lane computes one output lane: N+1 multipliers, PIPE registers, adder tree, requantise/saturate. It is instantiated J times by a generate loop; the top holds the input register, delay line, coefficient register, valid pipeline and counter.

Test Plan:
- Impulse:
  - Setup: defaults with PIPE=1; H tap i = 64*(i+1) loaded via H_LD; then one block DIN = {0,0,1023 on lane 0}, followed by zero blocks.
  - Expected: output blocks (lane0, lane1, lane2) = (63,127,191), (255,319,383), (447,511,575), then (0,0,0).
  - Expected: each VOUT occurs 3 cycles after its VIN.
- Saturation:
  - Setup: all taps -1024, all x = -1024.
  - Expected: once FULL=1 (after 4 blocks), every lane outputs 1023.
- Rounding:
  - Setup: h0=1, other taps 0, x=512 in all lanes.
  - Expected: ROUND=0 gives DOUT lanes 0; ROUND=1 gives 1.
- VIN gaps:
  - Setup: impulse stream with VIN pattern 1,0,0,1,0,1.
  - Expected: same DOUT sequence as the impulse test; VOUT pattern 1,0,0,1,0,1 delayed 3 cycles; DOUT stable during gaps.
- Coefficient swap:
  - Setup: H_LD asserted in the same cycle as accepting block m.
  - Expected: block m uses the old taps; block m+1 uses the new taps.
  - Also run with J=4, N=5, PIPE=0 against a reference model.
- Reset mid-stream:
  - Setup: RST=1 for one cycle while 2 blocks are in flight.
  - Expected: next cycle VOUT=0, DOUT=0, FULL=0; a following impulse reproduces the first test exactly.
